fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter for the async FIFO: shares the single write side (wr_en / wr_data into wr_ptr_ctrl and the RAM) between NUM_REQ producers in the write clock domain. Each grant is a bounded burst of up to MAX_BURST words. Transfers are back-pressured by the FIFO full flag.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (>= 2)
- DATA_WIDTH, 8, word width
- MAX_BURST, 4, max words per grant (>= 1)

Ports:
- clk  in  1  write-domain clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot; word accepted when valid & ready
- full  in  1  FIFO full flag from wr_ptr_ctrl
- wr_en  out  1  FIFO write strobe
- wr_data  out  DATA_WIDTH  FIFO write data
- grant  out  NUM_REQ  one-hot current owner, registered
- grant_id  out  $clog2(NUM_REQ)  index of owner, registered
- busy  out  1  high in BURST state

## Operation
- FSM states: IDLE and BURST. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, pick the first set bit searching upward from last_id+1, modulo NUM_REQ.
  - Register grant, grant_id and last_id; clear burst_cnt; next state is BURST.
- BURST:
  - xfer = req_valid[grant_id] & ~full.
  - wr_en = xfer; req_ready[grant_id] = xfer, all other ready bits 0; wr_data = req_data slice of grant_id.
  - Each xfer increments burst_cnt. burst_cnt width is $clog2(MAX_BURST+1).
- Burst ends and the next state is IDLE when either:
  - xfer occurs with burst_cnt == MAX_BURST-1, or
  - req_valid[grant_id] is low. This is a drop, and no write occurs that cycle.
- Full during BURST: no write, burst_cnt frozen, grant held. No timeout.
- Leaving BURST clears grant to 0. last_id retains the finished owner.
- The arbitration decision is used only in IDLE. Requests arriving during BURST wait.
- Reset values: state IDLE, grant 0, grant_id 0, last_id NUM_REQ-1 (requester 0 wins first), burst_cnt 0, busy 0. Consequently wr_en 0 and req_ready 0.

## Timing
- Grant latency: req_valid high in IDLE at edge N gives grant valid after edge N. First write occurs in that same cycle if full is low.
- One IDLE bubble cycle between consecutive bursts, including back-to-back grants to the same requester.
- wr_en, req_ready and wr_data are combinational from registered grant, req_valid, req_data and full. There is no added latency. wr_ptr_ctrl samples wr_en at the next clk edge.
- Reset assertion is asynchronous and immediately forces grant to 0, so wr_en and req_ready are 0 without a clock. Release is synchronous to clk in the usual two-flop reset synchronizer upstream.

## Configuration
- FIFO_WR_ARB_STATS_EN defined:
  - Adds output stall_cnt[15:0].
  - It increments on each BURST cycle with req_valid[grant_id] & full, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package fifo_arb_pkg: state enum (ST_IDLE, ST_BURST) and the stats counter width constant STALL_CNT_W = 16.
- Sub-module rr_pick: combinational. Inputs are req vector and last_id; outputs are the one-hot pick and its index. It wraps the request vector starting at last_id+1.
- Top holds the FSM, burst counter, output mux and optional stats counter.

## Test plan
All tests use NUM_REQ=4, MAX_BURST=4.
- Reset: rst=0 with req_valid=4'hF, full=0 -> wr_en=0, req_ready=0, grant=0, busy=0. After release, the first grant is 4'b0001.
- Single producer: req_valid=4'b0010 held for 10 words -> bursts of 4, 4 and 2 writes, each preceded by one IDLE cycle. 10 writes in 13 cycles, with data in order.
- Fairness: all four valid continuously -> grant sequence 0,1,2,3,0, with 4 writes each and 1 bubble between bursts.
- Full stall: full=1 for 3 cycles after the 2nd write of a burst -> wr_en=0 during the stall, grant held, 4 writes total. With the macro defined, stall_cnt=3.
- Drop: owner 2 deasserts valid after 2 writes while req 3 and req 0 are valid -> IDLE next cycle, then grant=4'b1000.
- Async reset mid-burst: rst low between clk edges -> wr_en and grant go to 0 at once. After release with req 1 and req 3 valid, requester 1 is granted first.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BURST
  } arb_state_e;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side signal bundle of the write-port arbiter.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [NUM_REQ-1:0]            grant;
  logic [IdW-1:0]                grant_id;
  logic                          busy;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, wr_en, wr_data, grant, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, wr_en, wr_data, grant, grant_id, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from last_id+1, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdW-1:0]     last_id,
  output logic [NUM_REQ-1:0] pick,
  output logic [IdW-1:0]     pick_id
);

  logic           found;
  logic [IdW-1:0] idx;

  always_comb begin
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IdW'((32'(last_id) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        pick_id   = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin bounded-burst arbiter for the async FIFO write port.
// Optional stall statistics counter enabled by defining FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_wr_arbiter_if.slave       bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IdW-1:0]     grant_id_q, grant_id_d;
  logic [IdW-1:0]     last_id_q, last_id_d;
  logic [CntW-1:0]    burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0] pick;
  logic [IdW-1:0]     pick_id;
  logic               in_burst;
  logic               own_valid;
  logic               xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdW     (IdW)
  ) u_rr_pick (
    .req     (bus.req_valid),
    .last_id (last_id_q),
    .pick    (pick),
    .pick_id (pick_id)
  );

  assign in_burst  = (state_q == ST_BURST);
  assign own_valid = bus.req_valid[grant_id_q];
  assign xfer      = in_burst & own_valid & ~bus.full;

  // Gating ready by grant_q lets an asynchronous reset silence the write port without a clock.
  assign bus.wr_en     = xfer;
  assign bus.req_ready = xfer ? grant_q : '0;
  assign bus.wr_data   = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.busy      = in_burst;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_id_d  = grant_id_q;
    last_id_d   = last_id_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          state_d     = ST_BURST;
          grant_d     = pick;
          grant_id_d  = pick_id;
          last_id_d   = pick_id;
          burst_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (!own_valid) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
          if (burst_cnt_q == LastBeat) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_id_q  <= '0;
      last_id_q   <= IdW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      last_id_q   <= last_id_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_burst && own_valid && bus.full && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic clk;
  logic rst;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int          total = 0;
  int          bad   = 0;
  int          remaining [NR];
  int          seq       [NR];
  logic        obs_wr;
  logic        obs_busy;
  logic [7:0]  obs_data;
  logic [3:0]  obs_grant;
  logic [3:0]  obs_ready;
  logic [1:0]  obs_gid;
  logic [31:0] wr_pat;
  int          wcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Producer i offers word {i, seq[i]} while it still has words left.
  task automatic drive();
    logic [3:0]  v;
    logic [31:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < int'(NR); i++) begin
      if (remaining[i] > 0) v = v | (4'b1 << i);
      d = d | (32'({2'(i), 6'(seq[i])}) << (8 * i));
    end
    bus.req_valid = v;
    bus.req_data  = d;
  endtask

  // One clock: drive after posedge, sample at negedge, retire accepted words.
  task automatic cycle();
    drive();
    #4;
    obs_wr    = bus.wr_en;
    obs_busy  = bus.busy;
    obs_data  = bus.wr_data;
    obs_grant = bus.grant;
    obs_ready = bus.req_ready;
    obs_gid   = bus.grant_id;
    for (int i = 0; i < int'(NR); i++) begin
      if (((obs_ready & (4'b1 << i)) != 4'b0) && (remaining[i] > 0)) begin
        remaining[i]--;
        seq[i]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    bus.full = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      remaining[i] = 0;
      seq[i]       = 0;
    end
    drive();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with all requests asserted
    rst           = 1'b1;
    bus.full      = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_data  = 32'h44332211;
    #1 rst = 1'b0;
    #11;
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("first_grant", 32'(bus.grant), 32'b0001);
    chk("first_busy", 32'(bus.busy), 32'd1);
    chk("first_wr_en", 32'(bus.wr_en), 32'd1);
    chk("first_ready", 32'(bus.req_ready), 32'b0001);
    chk("first_data", 32'(bus.wr_data), 32'h11);
    rst = 1'b0;
    #1;
    chk("async_grant0", 32'(bus.grant), 32'd0);
    chk("async_wr0", 32'(bus.wr_en), 32'd0);

    // Single producer 1 with 10 words: bursts 4,4,2 each after one idle cycle
    reset_dut();
    remaining[1] = 10;
    wr_pat = '0;
    wcount = 0;
    for (int c = 0; c < 13; c++) begin
      cycle();
      wr_pat = wr_pat | (32'(obs_wr) << c);
      if (obs_wr) begin
        chk("t2_data", 32'(obs_data), 32'({2'd1, 6'(wcount)}));
        chk("t2_ready", 32'(obs_ready), 32'b0010);
        wcount++;
      end
    end
    chk("t2_wr_pattern", wr_pat, 32'h1BDE);
    chk("t2_writes", 32'(wcount), 32'd10);
    cycle();
    chk("t2_drop_busy", 32'(obs_busy), 32'd1);
    chk("t2_drop_wr", 32'(obs_wr), 32'd0);
    cycle();
    chk("t2_idle_busy", 32'(obs_busy), 32'd0);

    // Fairness: all four valid, grants 0,1,2,3,0 with one bubble between
    reset_dut();
    for (int i = 0; i < int'(NR); i++) remaining[i] = 100;
    wr_pat = '0;
    for (int c = 0; c < 25; c++) begin
      cycle();
      wr_pat = wr_pat | (32'(obs_wr) << c);
      if (c % 5 == 2) chk("t3_grant", 32'(obs_grant), 32'(4'b1 << ((c / 5) % 4)));
    end
    chk("t3_wr_pattern", wr_pat, 32'h1EF7BDE);
    chk("t3_cnt0", 32'(seq[0]), 32'd8);
    chk("t3_cnt1", 32'(seq[1]), 32'd4);
    chk("t3_cnt2", 32'(seq[2]), 32'd4);
    chk("t3_cnt3", 32'(seq[3]), 32'd4);

    // Full stall for 3 cycles after the 2nd write of a burst
    reset_dut();
    remaining[0] = 4;
    wr_pat = '0;
    for (int c = 0; c < 9; c++) begin
      bus.full = (c >= 3 && c <= 5);
      cycle();
      wr_pat = wr_pat | (32'(obs_wr) << c);
      if (c == 4) begin
        chk("t4_stall_grant", 32'(obs_grant), 32'b0001);
        chk("t4_stall_ready", 32'(obs_ready), 32'd0);
      end
    end
    bus.full = 1'b0;
    chk("t4_wr_pattern", wr_pat, 32'hC6);
    chk("t4_writes", 32'(seq[0]), 32'd4);
    chk("t4_end_busy", 32'(obs_busy), 32'd0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("t4_stall_cnt", 32'(stall_cnt), 32'd3);
`endif

    // Drop: owner 2 stops after 2 writes while 3 and 0 wait
    reset_dut();
    remaining[2] = 2;
    cycle();
    remaining[3] = 4;
    remaining[0] = 4;
    cycle();
    chk("t5_w1_ready", 32'(obs_ready), 32'b0100);
    cycle();
    chk("t5_w2_wr", 32'(obs_wr), 32'd1);
    cycle();
    chk("t5_drop_wr", 32'(obs_wr), 32'd0);
    chk("t5_drop_ready", 32'(obs_ready), 32'd0);
    chk("t5_drop_grant", 32'(obs_grant), 32'b0100);
    cycle();
    chk("t5_idle_busy", 32'(obs_busy), 32'd0);
    chk("t5_idle_grant", 32'(obs_grant), 32'd0);
    cycle();
    chk("t5_next_grant", 32'(obs_grant), 32'b1000);
    chk("t5_next_gid", 32'(obs_gid), 32'd3);
    chk("t5_next_wr", 32'(obs_wr), 32'd1);

    // Asynchronous reset in the middle of a burst
    reset_dut();
    remaining[2] = 10;
    cycle();
    cycle();
    drive();
    #2;
    chk("t6_pre_wr", 32'(bus.wr_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_wr", 32'(bus.wr_en), 32'd0);
    chk("t6_async_grant", 32'(bus.grant), 32'd0);
    chk("t6_async_ready", 32'(bus.req_ready), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    remaining[2] = 0;
    remaining[1] = 4;
    remaining[3] = 4;
    drive();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_regrant", 32'(bus.grant), 32'b0010);
    chk("t6_regrant_id", 32'(bus.grant_id), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
